sev_seg_scan_display: RTL and testbench

Parametrised, time-multiplexed multi-digit seven-segment driver. It is the successor to the single-digit `sev_seg_display` decoder. The block latches a packed hex value with per-digit decimal points and scans the digits one at a time through shared segment lines. New values are committed only at frame boundaries, so the display never tears. Optional leading-zero suppression and selectable output polarity are provided. It sits between the datapath and the board's seven-segment pins.

---
 rtl/sev_seg_scan_display.sv | 139 +++++++++++++
 tb/tb_sev_seg_scan_display.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sev_seg_scan_display.sv
// Time-multiplexed multi-digit seven-segment driver. It latches a hex value and
// decimal points, commits them at frame boundaries, and scans one digit per dwell.
module sev_seg_scan_display #(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned REFRESH_DIV = 1000,
    parameter bit          ACTIVE_LOW  = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank_lz,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame,
    output logic                  pending
);

    localparam int unsigned VAL_W = 4 * DIGITS;
    localparam int unsigned PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [6:0]        SEG_OFF = {7{ACTIVE_LOW}};
    localparam logic [DIGITS-1:0] AN_OFF  = {DIGITS{ACTIVE_LOW}};

    logic [PRE_W-1:0]  pre;
    logic [IDX_W-1:0]  idx;
    logic [VAL_W-1:0]  disp_val;
    logic [DIGITS-1:0] disp_dp;
    logic [VAL_W-1:0]  pend_val;
    logic [DIGITS-1:0] pend_dp;

    logic              tick_c;
    logic              wrap_c;
    logic [PRE_W-1:0]  pre_nxt_c;
    logic [IDX_W-1:0]  idx_nxt_c;

    logic [3:0]        nib_c;
    logic              dp_sel_c;
    logic [DIGITS-1:0] an_raw_c;
    logic              blank_c;
    logic              upper_zero_c;
    logic [6:0]        seg_raw_c;

    function automatic logic [6:0] hex_decode(input logic [3:0] n);
        case (n)
            4'h0:    hex_decode = 7'h3F;
            4'h1:    hex_decode = 7'h06;
            4'h2:    hex_decode = 7'h5B;
            4'h3:    hex_decode = 7'h4F;
            4'h4:    hex_decode = 7'h66;
            4'h5:    hex_decode = 7'h6D;
            4'h6:    hex_decode = 7'h7D;
            4'h7:    hex_decode = 7'h07;
            4'h8:    hex_decode = 7'h7F;
            4'h9:    hex_decode = 7'h6F;
            4'hA:    hex_decode = 7'h77;
            4'hB:    hex_decode = 7'h7C;
            4'hC:    hex_decode = 7'h39;
            4'hD:    hex_decode = 7'h5E;
            4'hE:    hex_decode = 7'h79;
            default: hex_decode = 7'h71;
        endcase
    endfunction

    // Prescaler and digit index; a wrap of idx marks the frame/commit edge.
    always_comb begin
        tick_c    = (pre == PRE_W'(REFRESH_DIV - 1));
        wrap_c    = tick_c && (idx == IDX_W'(DIGITS - 1));
        pre_nxt_c = tick_c ? '0 : pre + PRE_W'(1);
        idx_nxt_c = idx;
        if (wrap_c) begin
            idx_nxt_c = '0;
        end else if (tick_c) begin
            idx_nxt_c = idx + IDX_W'(1);
        end
    end

    // Select the current digit; walking down from the top tracks whether all
    // digits at or above the current one are zero for leading-zero blanking.
    always_comb begin
        nib_c        = 4'h0;
        dp_sel_c     = 1'b0;
        an_raw_c     = '0;
        blank_c      = 1'b0;
        upper_zero_c = 1'b1;
        for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
            upper_zero_c = upper_zero_c && (disp_val[4*k +: 4] == 4'h0);
            if (idx == IDX_W'(k)) begin
                nib_c       = disp_val[4*k +: 4];
                dp_sel_c    = disp_dp[k];
                an_raw_c[k] = 1'b1;
                blank_c     = blank_lz && upper_zero_c && (k != 0);
            end
        end
        seg_raw_c = blank_c ? 7'h00 : hex_decode(nib_c);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre      <= '0;
            idx      <= '0;
            disp_val <= '0;
            disp_dp  <= '0;
            pend_val <= '0;
            pend_dp  <= '0;
            pending  <= 1'b0;
            frame    <= 1'b0;
            seg      <= SEG_OFF;
            dp       <= ACTIVE_LOW;
            an       <= AN_OFF;
        end else begin
            pre   <= pre_nxt_c;
            idx   <= idx_nxt_c;
            frame <= wrap_c;

            // The commit always takes the value pending before this edge, so a
            // coincident load becomes the next pending value.
            if (wrap_c && pending) begin
                disp_val <= pend_val;
                disp_dp  <= pend_dp;
            end
            if (load) begin
                pend_val <= value;
                pend_dp  <= dp_in;
                pending  <= 1'b1;
            end else if (wrap_c) begin
                pending  <= 1'b0;
            end

            seg <= seg_raw_c ^ SEG_OFF;
            dp  <= dp_sel_c ^ ACTIVE_LOW;
            an  <= an_raw_c ^ AN_OFF;
        end
    end

endmodule

// File: tb/tb_sev_seg_scan_display.sv
// Scoreboard bench for sev_seg_scan_display: expected scan frames are queued at
// load time and compared cycle by cycle against both polarities of the display.
module tb_sev_seg_scan_display;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       frame;
    } exp_t;

    localparam logic [6:0] HEX_TAB [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        blank_lz;

    logic [6:0]  seg,     seg_n;
    logic        dp,      dp_n;
    logic [3:0]  an,      an_n;
    logic        frame,   frame_n;
    logic        pending, pending_n;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t e;
    exp_t got;
    bit   ok;

    always #5 clk = ~clk;

    sev_seg_scan_display #(.DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in),
        .blank_lz(blank_lz), .seg(seg), .dp(dp), .an(an), .frame(frame),
        .pending(pending)
    );

    sev_seg_scan_display #(.DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(1'b1)) dut_n (
        .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in),
        .blank_lz(blank_lz), .seg(seg_n), .dp(dp_n), .an(an_n), .frame(frame_n),
        .pending(pending_n)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        load  = 1'b1;
        value = v;
        dp_in = d;
        step();
        load  = 1'b0;
    endtask

    // One frame of expected outputs: four cycles per digit, frame pulse on the last.
    task automatic push_frame(input logic [15:0] v, input logic [3:0] d,
                              input bit blz, input bit inv);
        exp_t       x;
        logic [3:0] nib;
        logic [6:0] s;
        logic [3:0] a;
        for (int k = 0; k < 4; k++) begin
            nib = v[4*k +: 4];
            s   = (blz && k != 0 && (v >> (4*k)) == 16'h0) ? 7'h00 : HEX_TAB[nib];
            a   = 4'b0001 << k;
            for (int r = 0; r < 4; r++) begin
                x.an    = inv ? ~a : a;
                x.seg   = inv ? ~s : s;
                x.dp    = inv ? ~d[k] : d[k];
                x.frame = (k == 3 && r == 3);
                exp_q.push_back(x);
            end
        end
    endtask

    task automatic wait_frame(input bit need_commit, output bit found);
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            step();
            if (frame && (!need_commit || !pending)) found = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b0; value = '0; dp_in = '0; blank_lz = 1'b0;
        repeat (3) step();
        checks++;
        if ({an, seg, dp, frame, pending} !== 14'h0) begin
            errors++;
            $display("FAIL reset_hi: got an=%b seg=%h dp=%b frame=%b pending=%b, want all 0",
                     an, seg, dp, frame, pending);
        end
        checks++;
        if ({an_n, seg_n, dp_n, frame_n, pending_n} !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_lo: got an=%b seg=%h dp=%b frame=%b pending=%b, want an=1111 seg=7f dp=1 frame=0 pending=0",
                     an_n, seg_n, dp_n, frame_n, pending_n);
        end
        rst = 1'b0;
        push_frame(16'h0000, 4'h0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            step();
            checks++;
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL reset_scan[%0d]: scoreboard empty", i);
            end else begin
                e = exp_q.pop_front();
                got = {an, seg, dp, frame};
                if (got !== e) begin
                    errors++;
                    $display("FAIL reset_scan[%0d]: got an=%b seg=%h dp=%b frame=%b, want an=%b seg=%h dp=%b frame=%b",
                             i, got.an, got.seg, got.dp, got.frame, e.an, e.seg, e.dp, e.frame);
                end
            end
        end
    endtask

    task automatic test_basic_scan();
        do_load(16'h1234, 4'h0);
        push_frame(16'h1234, 4'h0, 1'b0, 1'b0);
        push_frame(16'h1234, 4'h0, 1'b0, 1'b0);
        checks++;
        if (pending !== 1'b1) begin
            errors++; $display("FAIL basic_pending_rise: got %b want 1", pending);
        end
        wait_frame(1'b1, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL basic_commit: got no commit frame, want one within 64 cycles");
        end
        for (int i = 0; i < 32; i++) begin
            step();
            checks++;
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL basic_scan[%0d]: scoreboard empty", i);
            end else begin
                e = exp_q.pop_front();
                got = {an, seg, dp, frame};
                if (got !== e) begin
                    errors++;
                    $display("FAIL basic_scan[%0d]: got an=%b seg=%h dp=%b frame=%b, want an=%b seg=%h dp=%b frame=%b",
                             i, got.an, got.seg, got.dp, got.frame, e.an, e.seg, e.dp, e.frame);
                end
            end
        end
    endtask

    task automatic test_hex_dp();
        do_load(16'hABCD, 4'b0101);
        push_frame(16'hABCD, 4'b0101, 1'b0, 1'b0);
        wait_frame(1'b1, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL hex_commit: got no commit frame, want one within 64 cycles");
        end
        for (int i = 0; i < 16; i++) begin
            step();
            checks++;
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL hex_dp[%0d]: scoreboard empty", i);
            end else begin
                e = exp_q.pop_front();
                got = {an, seg, dp, frame};
                if (got !== e) begin
                    errors++;
                    $display("FAIL hex_dp[%0d]: got an=%b seg=%h dp=%b frame=%b, want an=%b seg=%h dp=%b frame=%b",
                             i, got.an, got.seg, got.dp, got.frame, e.an, e.seg, e.dp, e.frame);
                end
            end
        end
    endtask

    task automatic test_leading_zero();
        logic [15:0] vals [2];
        vals[0] = 16'h0050;
        vals[1] = 16'h0000;
        blank_lz = 1'b1;
        for (int t = 0; t < 2; t++) begin
            do_load(vals[t], 4'h0);
            push_frame(vals[t], 4'h0, 1'b1, 1'b0);
            wait_frame(1'b1, ok);
            checks++;
            if (!ok) begin
                errors++; $display("FAIL lz_commit[%0d]: got no commit frame, want one within 64 cycles", t);
            end
            for (int i = 0; i < 16; i++) begin
                step();
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL lz[%0d][%0d]: scoreboard empty", t, i);
                end else begin
                    e = exp_q.pop_front();
                    got = {an, seg, dp, frame};
                    if (got !== e) begin
                        errors++;
                        $display("FAIL lz[%0d][%0d]: got an=%b seg=%h dp=%b frame=%b, want an=%b seg=%h dp=%b frame=%b",
                                 t, i, got.an, got.seg, got.dp, got.frame, e.an, e.seg, e.dp, e.frame);
                    end
                end
            end
        end
        blank_lz = 1'b0;
    endtask

    task automatic test_load_collision();
        wait_frame(1'b0, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL coll_sync: got no frame, want one within 64 cycles");
        end
        // Positioned just after a wrap edge: the next wrap is 16 edges away.
        do_load(16'h1111, 4'h0);
        push_frame(16'h1111, 4'h0, 1'b0, 1'b0);
        repeat (14) step();
        do_load(16'h2222, 4'h0);
        push_frame(16'h2222, 4'h0, 1'b0, 1'b0);
        checks++;
        if ({frame, pending} !== 2'b11) begin
            errors++; $display("FAIL coll_edge: got frame=%b pending=%b, want frame=1 pending=1", frame, pending);
        end
        for (int i = 0; i < 32; i++) begin
            step();
            checks++;
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL collision[%0d]: scoreboard empty", i);
            end else begin
                e = exp_q.pop_front();
                got = {an, seg, dp, frame};
                if (got !== e) begin
                    errors++;
                    $display("FAIL collision[%0d]: got an=%b seg=%h dp=%b frame=%b, want an=%b seg=%h dp=%b frame=%b",
                             i, got.an, got.seg, got.dp, got.frame, e.an, e.seg, e.dp, e.frame);
                end
            end
            if (i == 14 || i == 15) begin
                checks++;
                if (pending !== (i == 14)) begin
                    errors++; $display("FAIL coll_pending[%0d]: got %b want %b", i, pending, (i == 14));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_load(16'h9999, 4'hF);
        ok = 1'b0;
        for (int i = 0; i < 32 && !ok; i++) begin
            step();
            if (an == 4'b0100) ok = 1'b1;
        end
        checks++;
        if (!ok || pending !== 1'b1) begin
            errors++; $display("FAIL rmid_setup: got found=%b pending=%b, want found=1 pending=1", ok, pending);
        end
        rst = 1'b1;
        load = 1'b1;
        value = 16'h7777;
        step();
        rst = 1'b0;
        load = 1'b0;
        checks++;
        if ({an, seg, dp, frame, pending} !== 14'h0) begin
            errors++;
            $display("FAIL rmid_off: got an=%b seg=%h dp=%b frame=%b pending=%b, want all 0",
                     an, seg, dp, frame, pending);
        end
        push_frame(16'h0000, 4'h0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            step();
            checks++;
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL rmid_scan[%0d]: scoreboard empty", i);
            end else begin
                e = exp_q.pop_front();
                got = {an, seg, dp, frame};
                if (got !== e) begin
                    errors++;
                    $display("FAIL rmid_scan[%0d]: got an=%b seg=%h dp=%b frame=%b, want an=%b seg=%h dp=%b frame=%b",
                             i, got.an, got.seg, got.dp, got.frame, e.an, e.seg, e.dp, e.frame);
                end
            end
        end
        checks++;
        if (pending !== 1'b0) begin
            errors++; $display("FAIL rmid_discard: got pending=%b want 0", pending);
        end
    endtask

    task automatic test_polarity();
        do_load(16'h1234, 4'h0);
        push_frame(16'h1234, 4'h0, 1'b0, 1'b1);
        wait_frame(1'b1, ok);
        checks++;
        if (!ok || pending_n !== 1'b0) begin
            errors++; $display("FAIL pol_commit: got found=%b pending=%b, want found=1 pending=0", ok, pending_n);
        end
        for (int i = 0; i < 16; i++) begin
            step();
            checks++;
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL polarity[%0d]: scoreboard empty", i);
            end else begin
                e = exp_q.pop_front();
                got = {an_n, seg_n, dp_n, frame_n};
                if (got !== e) begin
                    errors++;
                    $display("FAIL polarity[%0d]: got an=%b seg=%h dp=%b frame=%b, want an=%b seg=%h dp=%b frame=%b",
                             i, got.an, got.seg, got.dp, got.frame, e.an, e.seg, e.dp, e.frame);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_hex_dp();
        test_leading_zero();
        test_load_collision();
        test_reset_mid();
        test_polarity();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000 time units, want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
